// File: rtl/perf_report_pkg.sv
// Shared constants, FSM encoding and frame helpers for the performance-counter UART reporter.
package perf_report_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 14;
    localparam int         BITS_8N1  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [27:0] clk_cycles;
        logic [12:0] retired;
        logic [12:0] predictions;
        logic [12:0] correct;
        logic [12:0] invalid;
    } perf_snap_t;

    // XOR of payload bytes 1..12 (every field zero-extended, little-endian).
    function automatic logic [7:0] frame_checksum(input perf_snap_t s);
        logic [7:0] chk;
        chk = s.clk_cycles[7:0] ^ s.clk_cycles[15:8] ^ s.clk_cycles[23:16]
            ^ {4'h0, s.clk_cycles[27:24]}
            ^ s.retired[7:0]     ^ {3'b000, s.retired[12:8]}
            ^ s.predictions[7:0] ^ {3'b000, s.predictions[12:8]}
            ^ s.correct[7:0]     ^ {3'b000, s.correct[12:8]}
            ^ s.invalid[7:0]     ^ {3'b000, s.invalid[12:8]};
        return chk;
    endfunction

    function automatic logic [7:0] frame_byte(input perf_snap_t s, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = SYNC_BYTE;
            4'd1:    b = s.clk_cycles[7:0];
            4'd2:    b = s.clk_cycles[15:8];
            4'd3:    b = s.clk_cycles[23:16];
            4'd4:    b = {4'h0, s.clk_cycles[27:24]};
            4'd5:    b = s.retired[7:0];
            4'd6:    b = {3'b000, s.retired[12:8]};
            4'd7:    b = s.predictions[7:0];
            4'd8:    b = {3'b000, s.predictions[12:8]};
            4'd9:    b = s.correct[7:0];
            4'd10:   b = {3'b000, s.correct[12:8]};
            4'd11:   b = s.invalid[7:0];
            4'd12:   b = {3'b000, s.invalid[12:8]};
            4'd13:   b = frame_checksum(s);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready_o rises in the last cycle of the stop bit so a
// byte offered then starts its start bit with no idle gap.
module uart_tx_byte
    import perf_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                DATA_BITS = BITS_8N1 - 2;
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end_s;

    assign bit_end_s = (baud_cnt_q == BAUD_LAST);
    assign ready_o   = (state_q == IDLE) || ((state_q == STOP) && bit_end_s);
    assign tx_o      = tx_q;

    // Serializer state register; line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state and next tx level; tx_d is the level of the following cycle.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (valid_i) begin
                    state_d = START;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_cnt_d = '0;
                    if (valid_i) begin
                        state_d = START;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/perf_uart_reporter.sv
// Snapshots the core performance counters on start and streams them as a
// 14-byte 8N1 frame (sync, payload, XOR checksum) on tx.
module perf_uart_reporter
    import perf_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [27:0] clk_cycles,
    input  logic [12:0] retired_instructions,
    input  logic [12:0] predictions_made,
    input  logic [12:0] correct_predictions,
    input  logic [12:0] invalid_clk_cycles,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    perf_snap_t snap_q, snap_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] byte_idx_q, byte_idx_d;
    logic       ser_valid_s;
    logic [7:0] ser_data_s;
    logic       ser_ready_s;
    logic       ser_tx_s;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(ser_valid_s),
        .data_i (ser_data_s),
        .ready_o(ser_ready_s),
        .tx_o   (ser_tx_s)
    );

    assign tx   = ser_tx_s;
    assign busy = busy_q;
    assign done = done_q;

    // Frame sequencer registers and counter snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= 4'd0;
        end else begin
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // The sync byte goes straight to the serializer on accept (it needs no snapshot),
    // so the start bit appears the cycle after start is sampled.
    always_comb begin
        snap_d      = snap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        byte_idx_d  = byte_idx_q;
        ser_valid_s = 1'b0;
        ser_data_s  = SYNC_BYTE;
        if (!busy_q) begin
            if (start) begin
                snap_d.clk_cycles  = clk_cycles;
                snap_d.retired     = retired_instructions;
                snap_d.predictions = predictions_made;
                snap_d.correct     = correct_predictions;
                snap_d.invalid     = invalid_clk_cycles;
                busy_d             = 1'b1;
                byte_idx_d         = 4'd0;
                ser_valid_s        = 1'b1;
                ser_data_s         = SYNC_BYTE;
            end else begin
                busy_d = 1'b0;
            end
        end else if (ser_ready_s) begin
            if (byte_idx_q == LAST_IDX) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                byte_idx_d  = byte_idx_q + 4'd1;
                ser_valid_s = 1'b1;
                ser_data_s  = frame_byte(snap_q, byte_idx_q + 4'd1);
            end
        end else begin
            busy_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_perf_uart_reporter.sv
// Scoreboard bench: expected frame bytes are queued at stimulus time and a UART
// decoder process pops and compares every byte that appears on tx.
module tb_perf_uart_reporter;

    localparam int CPB = 4;
    typedef logic [7:0] frame_t [14];

    localparam frame_t FRAME_A = '{8'hA5, 8'h56, 8'h34, 8'h12, 8'h00, 8'hBC, 8'h0A,
                                   8'h10, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'hD9};
    localparam frame_t FRAME_MAX = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h1F,
                                     8'hFF, 8'h1F, 8'hFF, 8'h1F, 8'hFF, 8'h1F, 8'hF0};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [27:0] clk_cycles;
    logic [12:0] retired_instructions;
    logic [12:0] predictions_made;
    logic [12:0] correct_predictions;
    logic [12:0] invalid_clk_cycles;
    logic        tx;
    logic        busy;
    logic        done;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    logic [7:0] mon_byte;
    logic       mon_start;
    logic       mon_stop;
    logic       mon_abort;
    logic [7:0] mon_exp;

    perf_uart_reporter #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .clk_cycles          (clk_cycles),
        .retired_instructions(retired_instructions),
        .predictions_made    (predictions_made),
        .correct_predictions (correct_predictions),
        .invalid_clk_cycles  (invalid_clk_cycles),
        .tx                  (tx),
        .busy                (busy),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input frame_t f);
        for (int i = 0; i < 14; i++) exp_q.push_back(f[i]);
    endtask

    task automatic set_counters(input logic [27:0] c, input logic [12:0] r, input logic [12:0] p,
                                input logic [12:0] k, input logic [12:0] v);
        clk_cycles           = c;
        retired_instructions = r;
        predictions_made     = p;
        correct_predictions  = k;
        invalid_clk_cycles   = v;
    endtask

    // Pulse start for one cycle; returns at the negedge of the first start-bit cycle.
    task automatic begin_frame(input bit zero_after);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (zero_after) set_counters(28'd0, 13'd0, 13'd0, 13'd0, 13'd0);
        chk("start_bit_tx", tx, 1'b0);
        chk("start_busy", busy, 1'b1);
        chk("start_done", done, 1'b0);
    endtask

    // Count cycles from the first start-bit cycle to done; optionally pulse start mid-frame.
    task automatic wait_done(input int mid_at);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 700) begin
            @(negedge clk);
            n++;
            start = (n == mid_at);
        end
        chk("frame_len", n, 560);
        chk("done_busy", busy, 1'b0);
        chk("done_tx", tx, 1'b1);
    endtask

    // UART decoder: samples mid-bit, aborts a byte if reset is seen.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_start = 1'b1;
                mon_stop  = 1'b0;
                mon_byte  = 8'h00;
                for (int off = 1; off <= 39; off++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) mon_abort = 1'b1;
                    if (off == 2) mon_start = tx;
                    else if (off == 38) mon_stop = tx;
                    else if (off >= 6 && off <= 34 && (off % 4) == 2) mon_byte[(off - 6) / 4] = tx;
                end
                if (!mon_abort) begin
                    chk("framing", {30'd0, mon_start, mon_stop}, 32'd1);
                    chk("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        chk("frame_byte", mon_byte, mon_exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        start = 1'b0;
        set_counters(28'd0, 13'd0, 13'd0, 13'd0, 13'd0);

        // 1: reset and idle
        repeat (5) @(negedge clk);
        chk("reset_outputs", {29'd0, tx, busy, done}, 32'd4);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outputs", {29'd0, tx, busy, done}, 32'd4);
        end

        // 2: basic frame
        set_counters(28'h0123456, 13'h0ABC, 13'h0010, 13'h000C, 13'h0003);
        push_frame(FRAME_A);
        begin_frame(1'b0);
        wait_done(-1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        repeat (10) @(negedge clk);

        // 3: inputs cleared right after accept
        set_counters(28'h0123456, 13'h0ABC, 13'h0010, 13'h000C, 13'h0003);
        push_frame(FRAME_A);
        begin_frame(1'b1);
        wait_done(-1);
        repeat (10) @(negedge clk);

        // 4: ignored mid-frame start, then back-to-back start in the done cycle
        set_counters(28'h0123456, 13'h0ABC, 13'h0010, 13'h000C, 13'h0003);
        push_frame(FRAME_A);
        push_frame(FRAME_A);
        begin_frame(1'b0);
        wait_done(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_start_bit", tx, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        wait_done(-1);
        repeat (10) @(negedge clk);

        // 5: asynchronous reset mid-byte, then a clean frame
        push_frame(FRAME_A);
        begin_frame(1'b0);
        repeat (250) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_rst_idle", {29'd0, tx, busy, done}, 32'd4);
        push_frame(FRAME_A);
        begin_frame(1'b0);
        wait_done(-1);
        repeat (10) @(negedge clk);

        // 6: all counters at maximum
        set_counters(28'hFFFFFFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
        push_frame(FRAME_MAX);
        begin_frame(1'b0);
        wait_done(-1);

        repeat (60) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
